prbs_gen_chk: RTL and testbench
===============================

// Module: prbs_gen_chk
// PURPOSE
//  Parametrised Fibonacci LFSR pseudo-random bit generator plus self-synchronising checker.
//  Generator drives test bit streams (defaults give the 4-bit m-sequence, period 15).
//  Checker locks onto a received stream and counts bit errors.
//  Used for loopback and link bring-up tests.
// PARAMETERS
//  WIDTH     4        LFSR length (2..32)
//  TAPS      4'b1001  feedback mask; fb = ^(reg & TAPS); must give a maximal-length sequence
//  SEED      all-1s   reset/default seed (WIDTH bits); must be nonzero
//  LOCK_CNT  8        consecutive matches in CHECK needed to enter LOCK (1..255)
//  LOSS_THR  3        consecutive mismatches in LOCK that force HUNT (1..255)
//  ERR_W     8        error counter width
// PORTS
//  clk        in   1      clock, rising edge
//  res        in   1      asynchronous reset, active low
//  en         in   1      generator advance enable
//  seed_ld    in   1      load seed into generator
//  seed       in   WIDTH  seed value for seed_ld
//  y          out  1      generator output bit = g[0]
//  rx_en      in   1      rx_bit valid this cycle
//  rx_bit     in   1      received bit
//  err_clr    in   1      clear err_cnt
//  locked     out  1      checker in LOCK
//  err_pulse  out  1      one-cycle flag: mismatch seen in LOCK
//  err_cnt    out  ERR_W  saturating mismatch count, LOCK state only
// BEHAVIOUR
//  Reset (res=0, async): g=SEED, y=SEED[0], state=HUNT, fill=0, c=0; locked, err_pulse, err_cnt = 0.
//  Generator, per rising edge:
//   - seed_ld=1 -> g=seed; if seed==0, g=SEED (prevents lockup).
//   - seed_ld has priority over en.
//   - en=1 and seed_ld=0 -> g={fb(g), g[WIDTH-1:1]}.
//   - Otherwise g holds.
//  Default-parameter sequence after reset, en=1 every cycle:
//   - g: 1111,0111,1011,0101,1010,1101,0110,0011,1001,0100,0010,0001,1000,1100,1110, repeat.
//   - y: 1,1,1,1,0,1,0,1,1,0,0,1,0,0,0, repeat.
//  Checker: register c, expected bit e = fb(c); state codes HUNT=0, CHECK=1, LOCK=2.
//  Nothing changes on cycles with rx_en=0, except err_pulse clearing and err_clr.
//   HUNT:  c={rx_bit, c[W-1:1]}; fill++; after the WIDTH-th bit -> CHECK with match=0.
//   CHECK: c={rx_bit, c[W-1:1]}.
//          rx_bit==e: match++; match reaching LOCK_CNT -> LOCK, miss=0.
//          rx_bit!=e: match=0, stay in CHECK. No err_cnt/err_pulse activity.
//   LOCK (flywheel): c={e, c[W-1:1]}.
//          rx_bit!=e: err_pulse=1 next cycle; err_cnt++ (saturates at all-1s); miss++.
//          miss reaching LOSS_THR -> HUNT, fill=0.
//          rx_bit==e: miss=0.
//  locked is registered: 1 in the cycle after the edge that enters LOCK; 0 after the edge leaving it.
//  err_clr:
//   - Sets err_cnt=0 on the next edge.
//   - Same edge as an increment -> err_cnt=1.
//   - err_cnt holds its value across HUNT/CHECK.
//  Loopback lock latency (rx_bit=y, rx_en=en=1): WIDTH+LOCK_CNT accepted bits (12 at defaults).
//  Generator and checker are independent; seed_ld does not disturb the checker.
//  All state is cleared by async reset at any time, including mid-LOCK; no sync reset.
// STRUCTURE
//  - Header prbs_defs.vh: state codes HUNT/CHECK/LOCK, default TAPS/SEED for WIDTH 4/7/15/23/31.
//  - Sub-module prbs_lfsr (WIDTH, TAPS): combinational fb and next-state.
//    Instantiated twice: generator and checker flywheel.
//  - Top holds the registers, the FSM, and the match/miss/fill counters (8-bit).
// TESTING
//  1 Reset, release, en=1 for 30 cycles -> y = 111101011001000 twice.
//  2 seed_ld with seed=4'b0000 -> g=1111. seed_ld with seed=4'b1000, en=1 on same edge -> g=1000, no advance.
//  3 Loopback rx_bit=y, rx_en=1 from reset release -> locked rises after the 12th accepted bit.
//    err_cnt stays 0 over 100 bits.
//  4 In LOCK, invert one rx_bit -> err_pulse for exactly 1 cycle, err_cnt=1, locked stays 1.
//    Assert err_clr on that same edge -> err_cnt=1.
//  5 In LOCK, 3 consecutive inverted bits -> err_cnt=3, locked=0 after 3rd.
//    Restore loopback -> relock after 12 bits. rx_en gaps delay lock by exactly the gap length.
//  6 Assert res mid-LOCK with err_cnt=5 -> all outputs at reset values immediately, without a clock edge.

Source files
------------

// File: rtl/prbs_gen_chk_pkg.sv
// Shared checker state encoding, counter width and default LFSR tap masks
// for the PRBS generator/checker.
package prbs_gen_chk_pkg;

  // Checker states; the numeric codes are visible on debug probes.
  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_LOCK  = 2'd2
  } chk_state_e;

  // Width of the fill/match/miss counters.
  localparam int CNT_W = 8;

  // Maximal-length tap masks for the common PRBS lengths. Bit 0 is always
  // tapped and the second tap selects x^n + x^k + 1. For any other length a
  // generic two-tap mask is returned, which is not guaranteed to be
  // maximal-length, so the instantiating block should set TAPS explicitly.
  function automatic logic [31:0] prbs_default_taps(input int width);
    case (width)
      4:       return 32'h0000_0009;
      7:       return 32'h0000_0041;
      15:      return 32'h0000_4001;
      23:      return 32'h0004_0001;
      31:      return 32'h1000_0001;
      default: return (32'h1 << (width - 1)) | 32'h1;
    endcase
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Combinational Fibonacci LFSR step. It shifts right and inserts the
// feedback bit fb = ^(state & TAPS) at the MSB, so nxt_o[WIDTH-1] is the
// feedback (predicted) bit.
module prbs_lfsr #(
  parameter int              WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = 4'b1001
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] nxt_o
);

  logic fb;

  // Feedback parity and the shifted next state.
  always_comb begin
    fb    = ^(state_i & TAPS);
    nxt_o = {fb, state_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS generator plus self-synchronising checker for loopback and link
// bring-up. The generator and the checker share only the LFSR polynomial.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_HUNT  | shifting received bits into c until WIDTH bits are collected
//  ST_CHECK | comparing rx_bit with fb(c), counting consecutive matches
//  ST_LOCK  | c runs as a flywheel on its own prediction; mismatches counted
module prbs_gen_chk
  import prbs_gen_chk_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(prbs_default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED     = '1,
  parameter int               LOCK_CNT = 8,
  parameter int               LOSS_THR = 3,
  parameter int               ERR_W    = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             seed_ld,
  input  logic [WIDTH-1:0] seed,
  output logic             y,
  input  logic             rx_en,
  input  logic             rx_bit,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] c_q, c_d;
  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] gen_nxt;
  logic [WIDTH-1:0] chk_nxt;
  logic [WIDTH-1:0] shift_rx;
  logic             exp_bit;
  logic             err_inc;
  logic [CNT_W-1:0] fill_inc, match_inc, miss_inc;

  prbs_lfsr #(.WIDTH(WIDTH), .TAPS(TAPS)) u_gen_lfsr (
    .state_i (g_q),
    .nxt_o   (gen_nxt)
  );

  // The checker copy also provides the expected bit: its MSB is fb(c).
  prbs_lfsr #(.WIDTH(WIDTH), .TAPS(TAPS)) u_chk_lfsr (
    .state_i (c_q),
    .nxt_o   (chk_nxt)
  );

  // Generator next state: a load takes priority over advancing, and a zero seed
  // falls back to SEED so the LFSR cannot stick at all-zeros.
  always_comb begin
    g_d = g_q;
    if (seed_ld) begin
      g_d = (seed == '0) ? SEED : seed;
    end else if (en) begin
      g_d = gen_nxt;
    end
  end

  // Checker FSM: next state, counters, and error bookkeeping.
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    exp_bit     = chk_nxt[WIDTH-1];
    shift_rx    = {rx_bit, c_q[WIDTH-1:1]};
    fill_inc    = fill_q + 8'd1;
    match_inc   = match_q + 8'd1;
    miss_inc    = miss_q + 8'd1;

    if (rx_en) begin
      case (state_q)
        ST_HUNT: begin
          c_d = shift_rx;
          if (fill_inc == CNT_W'(WIDTH)) begin
            state_d = ST_CHECK;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_inc;
          end
        end
        ST_CHECK: begin
          c_d = shift_rx;
          if (rx_bit == exp_bit) begin
            if (match_inc == CNT_W'(LOCK_CNT)) begin
              state_d = ST_LOCK;
              miss_d  = '0;
              match_d = '0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = '0;
          end
        end
        ST_LOCK: begin
          c_d = chk_nxt;
          if (rx_bit != exp_bit) begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            if (miss_inc == CNT_W'(LOSS_THR)) begin
              state_d = ST_HUNT;
              fill_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: begin
          state_d = ST_HUNT;
          fill_d  = '0;
        end
      endcase
    end

    // err_clr acts even with rx_en low. A clear on the same edge as an
    // increment leaves a count of one.
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = err_inc ? ERR_W'(1) : '0;
    end else if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end

    locked_d = (state_d == ST_LOCK);
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      g_q         <= SEED;
      c_q         <= '0;
      state_q     <= ST_HUNT;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      g_q         <= g_d;
      c_q         <= c_d;
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign y         = g_q[0];
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Bench for prbs_gen_chk at default parameters: generator vector table,
// hand sequences for lock/loss/error corners, then random stimulus against
// a bit-history reference model.
module tb_prbs_gen_chk;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       en = 1'b0, seed_ld = 1'b0, rx_en = 1'b0, rx_bit = 1'b0, err_clr = 1'b0;
  logic [3:0] seed = 4'h0;
  logic       y, locked, err_pulse;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  prbs_gen_chk dut (
    .clk       (clk),
    .res       (res),
    .en        (en),
    .seed_ld   (seed_ld),
    .seed      (seed),
    .y         (y),
    .rx_en     (rx_en),
    .rx_bit    (rx_bit),
    .err_clr   (err_clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // m-sequence states after reset, as listed for x^4 + x^3 + 1 from 1111
  logic [3:0] gseq [15] = '{4'b1111, 4'b0111, 4'b1011, 4'b0101, 4'b1010,
                            4'b1101, 4'b0110, 4'b0011, 4'b1001, 4'b0100,
                            4'b0010, 4'b0001, 4'b1000, 4'b1100, 4'b1110};
  logic [0:14] ypat = 15'b111101011001000;

  typedef struct {
    logic       en;
    logic       seed_ld;
    logic [3:0] seed;
    logic       exp_y;
  } gvec_t;
  gvec_t vtab[$];

  // reference model state
  int   m_gidx, m_state, m_fill, m_match, m_miss, m_err;
  logic m_pulse;
  logic m_hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res = 1'b0; en = 1'b0; seed_ld = 1'b0; seed = 4'h0;
    rx_en = 1'b0; rx_bit = 1'b0; err_clr = 1'b0;
    tick();
    tick();
    res = 1'b1;
  endtask

  task automatic add_g(input logic e, input logic ld, input logic [3:0] s, input logic ey);
    gvec_t v;
    v.en = e; v.seed_ld = ld; v.seed = s; v.exp_y = ey;
    vtab.push_back(v);
  endtask

  // loopback drive: rx_bit follows the current generator bit, optionally inverted
  task automatic drive(input logic e, input logic re, input logic flip, input logic clr);
    en = e; rx_en = re; rx_bit = y ^ flip; err_clr = clr; seed_ld = 1'b0;
    tick();
  endtask

  function automatic int gidx_of(input logic [3:0] v);
    for (int i = 0; i < 15; i++) if (gseq[i] == v) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_gidx = 0; m_state = 0; m_fill = 0; m_match = 0; m_miss = 0; m_err = 0;
    m_pulse = 1'b0;
    m_hist.delete();
  endtask

  task automatic hist_push(input logic b);
    m_hist.push_back(b);
    if (m_hist.size() > 4) void'(m_hist.pop_front());
  endtask

  // Predicted bit from the recurrence y[t+4] = y[t] ^ y[t+3] on the last four bits.
  task automatic model_step(input logic i_en, input logic i_ld, input logic [3:0] i_seed,
                            input logic i_rxen, input logic i_rx, input logic i_clr);
    logic e;
    logic inc;
    if (i_ld) m_gidx = gidx_of((i_seed == 4'h0) ? 4'hF : i_seed);
    else if (i_en) m_gidx = (m_gidx + 1) % 15;
    m_pulse = 1'b0;
    inc = 1'b0;
    if (i_rxen) begin
      case (m_state)
        0: begin
          hist_push(i_rx);
          m_fill++;
          if (m_fill == 4) begin m_state = 1; m_fill = 0; m_match = 0; end
        end
        1: begin
          e = m_hist[0] ^ m_hist[3];
          hist_push(i_rx);
          if (i_rx == e) begin
            m_match++;
            if (m_match == 8) begin m_state = 2; m_miss = 0; end
          end else m_match = 0;
        end
        default: begin
          e = m_hist[0] ^ m_hist[3];
          hist_push(e);
          if (i_rx != e) begin
            m_pulse = 1'b1;
            inc = 1'b1;
            m_miss++;
            if (m_miss == 3) begin m_state = 0; m_fill = 0; end
          end else m_miss = 0;
        end
      endcase
    end
    if (i_clr) m_err = inc ? 1 : 0;
    else if (inc && m_err < 255) m_err++;
  endtask

  initial begin
    logic flip;
    int   r;

    // ---------------- generator table ----------------
    for (int i = 1; i <= 30; i++) add_g(1'b1, 1'b0, 4'h0, ypat[i % 15]);
    add_g(1'b0, 1'b1, 4'b0000, 1'b1);   // zero seed -> 1111
    add_g(1'b1, 1'b0, 4'h0, 1'b1);      // 0111
    add_g(1'b1, 1'b0, 4'h0, 1'b1);      // 1011
    add_g(1'b1, 1'b0, 4'h0, 1'b1);      // 0101
    add_g(1'b1, 1'b0, 4'h0, 1'b0);      // 1010
    add_g(1'b1, 1'b1, 4'b1000, 1'b0);   // load beats en -> 1000
    add_g(1'b1, 1'b0, 4'h0, 1'b0);      // 1100
    add_g(1'b1, 1'b0, 4'h0, 1'b0);      // 1110
    add_g(1'b0, 1'b0, 4'h0, 1'b0);      // hold
    add_g(1'b0, 1'b0, 4'h0, 1'b0);      // hold
    add_g(1'b1, 1'b0, 4'h0, 1'b1);      // 1111
    add_g(1'b1, 1'b0, 4'h0, 1'b1);      // 0111

    do_reset();
    check("reset_y", y, 1);
    check("reset_locked", locked, 0);
    check("reset_err_pulse", err_pulse, 0);
    check("reset_err_cnt", err_cnt, 0);
    foreach (vtab[i]) begin
      en = vtab[i].en; seed_ld = vtab[i].seed_ld; seed = vtab[i].seed;
      tick();
      check($sformatf("gen_vec%0d", i), y, vtab[i].exp_y);
    end

    // ---------------- loopback lock latency ----------------
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      if (k == 11) check("lock_lat_before", locked, 0);
      if (k == 12) check("lock_lat_at12", locked, 1);
    end
    for (int k = 0; k < 100; k++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("lb100_err_cnt", err_cnt, 0);
    check("lb100_locked", locked, 1);

    // ---------------- single error in LOCK ----------------
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("single_err_pulse", err_pulse, 1);
    check("single_err_cnt", err_cnt, 1);
    check("single_err_locked", locked, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("single_err_pulse_end", err_pulse, 0);
    check("single_err_cnt_hold", err_cnt, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_with_inc", err_cnt, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_alone", err_cnt, 0);
    check("clr_locked", locked, 1);

    // ---------------- loss of lock and relock ----------------
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      if (k == 2) check("loss_locked_after2", locked, 1);
    end
    check("loss_locked_after3", locked, 0);
    check("loss_err_cnt", err_cnt, 3);
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      if (k == 11) check("relock_before", locked, 0);
      if (k == 12) check("relock_at12", locked, 1);
    end

    // mismatch while in CHECK: no error activity
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("check_miss_pulse", err_pulse, 0);
    check("check_miss_cnt", err_cnt, 6);
    for (int k = 0; k < 30; k++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("check_miss_relock", locked, 1);
    check("check_miss_cnt_after", err_cnt, 6);

    // rx_en gaps (generator paused too) delay lock by the gap length
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("gap_loss_err_cnt", err_cnt, 9);
    for (int k = 1; k <= 15; k++) begin
      if (k == 3 || k == 7 || k == 10) drive(1'b0, 1'b0, 1'b0, 1'b0);
      else drive(1'b1, 1'b1, 1'b0, 1'b0);
      if (k == 14) check("gap_lock_before", locked, 0);
      if (k == 15) check("gap_lock_at15", locked, 1);
    end

    // ---------------- error counter saturation ----------------
    for (int k = 0; k < 260; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
    end
    check("sat_err_cnt", err_cnt, 255);
    check("sat_locked", locked, 1);

    // ---------------- async reset mid-LOCK ----------------
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      if (k < 5) drive(1'b1, 1'b1, 1'b0, 1'b0);
    end
    check("pre_reset_err_cnt", err_cnt, 5);
    check("pre_reset_pulse", err_pulse, 1);
    #2;
    res = 1'b0;
    #1;
    check("async_rst_locked", locked, 0);
    check("async_rst_pulse", err_pulse, 0);
    check("async_rst_err_cnt", err_cnt, 0);
    check("async_rst_y", y, 1);

    // ---------------- random stimulus vs model ----------------
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r       = $urandom_range(0, 99);
      seed_ld = (r < 2);
      seed    = (r == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      rx_en   = ($urandom_range(0, 9) != 0);
      en      = rx_en;
      if ($urandom_range(0, 31) == 0) en = ~en;
      flip    = ($urandom_range(0, 39) == 0);
      rx_bit  = gseq[m_gidx][0] ^ flip;
      err_clr = ($urandom_range(0, 63) == 0);
      model_step(en, seed_ld, seed, rx_en, rx_bit, err_clr);
      tick();
      check($sformatf("rnd%0d_y", cyc), y, gseq[m_gidx][0]);
      check($sformatf("rnd%0d_locked", cyc), locked, (m_state == 2) ? 1 : 0);
      check($sformatf("rnd%0d_pulse", cyc), err_pulse, m_pulse);
      check($sformatf("rnd%0d_err_cnt", cyc), err_cnt, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
